// File: rtl/rv_fp_pkg.sv
// rv_fp_pkg: shared fp64 word type, widths and source-index width helper
package rv_fp_pkg;

    typedef struct packed {
        logic        sign;
        logic [10:0] expo;
        logic [51:0] frac;
    } fp_t_e_11_f_52;

    localparam int FP_W = 64;
    localparam int FP_E = 11;
    localparam int FP_F = 52;

    function automatic int src_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating priority encoder, first request after last with wrap
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);

    logic [W-1:0] j;

    // scan farthest-to-nearest so the nearest requester after last wins
    always_comb begin
        gnt = '0;
        idx = '0;
        j   = '0;
        for (int k = N; k >= 1; k--) begin
            j = W'((int'(last) + k) % N);
            if (req[j]) begin
                gnt = N'(1) << j;
                idx = j;
            end
        end
    end

endmodule

// File: rtl/rv_fp_arbiter.sv
// rv_fp_arbiter: round-robin burst-locking arbiter feeding one fp64 stream; RVARB_STATS_EN adds stat_cnt
module rv_fp_arbiter
    import rv_fp_pkg::*;
#(
    parameter int N     = 4,
    parameter int BURST = 4,
    parameter int E     = 11,
    parameter int F     = 52,
    localparam int SW   = src_w(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N*64-1:0]   s_data,
    input  logic [N-1:0]      s_valid,
    output logic [N-1:0]      s_ready,
    output logic [63:0]       m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [SW-1:0]     m_src
`ifdef RVARB_STATS_EN
    ,
    output logic [N*16-1:0]   stat_cnt
`endif
);

    if (E != FP_E || F != FP_F) begin : g_width_check
        $error("rv_fp_arbiter: E/F must be 11/52");
    end

    fp_t_e_11_f_52 word;
    logic [N-1:0]  pgnt;
    logic [N-1:0]  sel;
    logic [SW-1:0] pidx;
    logic [SW-1:0] grant;
    logic [SW-1:0] last;
    logic [SW-1:0] owner;
    logic [7:0]    count;
    logic [7:0]    count_nx;
    logic          lock;
    logic          load_en;
    logic          lock_hit;
    logic          accept;

    rr_pick #(.N(N), .W(SW)) u_pick (
        .req  (s_valid),
        .last (last),
        .gnt  (pgnt),
        .idx  (pidx)
    );

    // a held burst owner overrides the rotation while it keeps requesting
    always_comb begin
        load_en  = !m_valid || m_ready;
        lock_hit = lock && s_valid[owner];
        grant    = lock_hit ? owner : pidx;
        sel      = lock_hit ? N'(1) << owner : pgnt;
        accept   = load_en && |s_valid && !reset;
        s_ready  = accept ? sel : '0;
        word     = s_data[FP_W*grant +: FP_W];
        count_nx = (lock && owner == grant) ? count + 8'd1 : 8'd1;
    end

    // output stage plus arbitration state; everything freezes while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_src   <= '0;
            last    <= SW'(N - 1);
            owner   <= '0;
            count   <= '0;
            lock    <= 1'b0;
        end else if (load_en) begin
            m_valid <= accept;
            if (accept) begin
                m_data <= word;
                m_src  <= grant;
                last   <= grant;
                owner  <= grant;
                count  <= count_nx;
                lock   <= count_nx < 8'(BURST);
            end else begin
                lock <= 1'b0;
            end
        end
    end

`ifdef RVARB_STATS_EN
    // saturating per-requester accepted-word counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_cnt <= '0;
        end else begin
            for (int i = 0; i < N; i++)
                if (s_ready[i] && stat_cnt[16*i +: 16] != 16'hFFFF)
                    stat_cnt[16*i +: 16] <= stat_cnt[16*i +: 16] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rv_fp_arbiter.sv
// tb_rv_fp_arbiter: directed and random checks of rv_fp_arbiter against a burst-budget model
module tb_rv_fp_arbiter;

    localparam int BURST = 4;
    localparam logic [63:0] NAN_W = 64'h7FF8_0000_0000_0001;
    localparam logic [63:0] INF_W = 64'h7FF0_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sv;
    logic [63:0] sd [4];
    logic        mr;
    logic [255:0] s_data;
    logic [3:0]  s_ready, s_ready1;
    logic [63:0] m_data, m_data1;
    logic        m_valid, m_valid1;
    logic [1:0]  m_src, m_src1;
`ifdef RVARB_STATS_EN
    logic [63:0] stat_cnt, stat_cnt1;
`endif

    int total = 0;
    int bad = 0;

    logic        mv_e;
    logic [63:0] md_e;
    int          ms_e, last_e, owner_e, left_e;
    logic [3:0]  rdy_e, rdy_seen;

    assign s_data = {sd[3], sd[2], sd[1], sd[0]};

    always #5 clk = ~clk;

    rv_fp_arbiter #(.N(4), .BURST(BURST)) u0 (
        .clk(clk), .reset(rst), .s_data(s_data), .s_valid(sv), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(mr), .m_src(m_src)
`ifdef RVARB_STATS_EN
        , .stat_cnt(stat_cnt)
`endif
    );

    rv_fp_arbiter #(.N(4), .BURST(1)) u1 (
        .clk(clk), .reset(rst), .s_data(s_data), .s_valid(sv), .s_ready(s_ready1),
        .m_data(m_data1), .m_valid(m_valid1), .m_ready(mr), .m_src(m_src1)
`ifdef RVARB_STATS_EN
        , .stat_cnt(stat_cnt1)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // the still-budgeted owner keeps the stream, otherwise nearest requester after last
    function automatic int pick();
        if (left_e > 0 && sv[owner_e]) return owner_e;
        for (int k = 1; k <= 4; k++)
            if (sv[(last_e + k) % 4]) return (last_e + k) % 4;
        return -1;
    endfunction

    task automatic cycle();
        int g;
        bit ld;
        #1;
        g = pick();
        ld = !mv_e || mr;
        rdy_e = (!rst && ld && g >= 0) ? 4'(1 << g) : 4'd0;
        rdy_seen = s_ready;
        check("s_ready", 64'(rdy_seen), 64'(rdy_e));
        @(posedge clk);
        if (rst) begin
            mv_e = 0; md_e = 0; ms_e = 0; last_e = 3; owner_e = 0; left_e = 0;
        end else if (ld) begin
            if (g >= 0) begin
                mv_e = 1; md_e = sd[g]; ms_e = g; last_e = g;
                if (g == owner_e && left_e > 0) left_e--;
                else begin owner_e = g; left_e = BURST - 1; end
            end else begin
                mv_e = 0; left_e = 0;
            end
        end
        @(negedge clk);
        check("m_valid", 64'(m_valid), 64'(mv_e));
        check("m_data", m_data, md_e);
        check("m_src", 64'(m_src), 64'(ms_e));
    endtask

    task automatic do_reset();
        rst = 1; sv = 0; mr = 1;
        cycle();
        cycle();
        rst = 0;
    endtask

    initial begin
        rst = 1; sv = 0; mr = 1; mv_e = 0; md_e = 0; ms_e = 0;
        last_e = 3; owner_e = 0; left_e = 0;
        for (int i = 0; i < 4; i++) sd[i] = 0;
        @(negedge clk);
        do_reset();
        check("rst_m_valid", 64'(m_valid), 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_src", 64'(m_src), 0);
        check("rst_m_valid_b1", 64'(m_valid1), 0);

        // all four streaming, BURST=1 copy rotates every word
        for (int i = 0; i < 4; i++) sd[i] = 64'h3FF0_0000_0000_0000 + 64'(i);
        sv = 4'hF;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("b1_valid", 64'(m_valid1), 1);
            check("b1_src", 64'(m_src1), 64'(k % 4));
            check("b1_data", m_data1, 64'h3FF0_0000_0000_0000 + 64'(k % 4));
        end

        // requesters 0 and 2 with BURST=4
        do_reset();
        sv = 4'b0101;
        for (int k = 0; k < 9; k++) begin
            cycle();
            if (k < 4) check("b4_rdy2_low", 64'(rdy_seen[2]), 0);
            check("b4_src", 64'(m_src), (k < 4 || k == 8) ? 0 : 2);
        end

        // owner 1 leaves mid-burst, 3 takes over the same cycle with a fresh count
        do_reset();
        sd[1] = 64'h4000_0000_0000_0001;
        sv = 4'b0010;
        cycle();
        cycle();
        sd[3] = 64'hC000_0000_0000_0003;
        sv = 4'b1000;
        cycle();
        check("vol_rdy3", 64'(rdy_seen), 64'(4'b1000));
        check("vol_src", 64'(m_src), 3);
        sv = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("vol_burst_src", 64'(m_src), (k < 3) ? 3 : 1);
        end

        // stall holding a NaN, then an Inf follows intact
        do_reset();
        sd[0] = NAN_W;
        sv = 4'b0001;
        cycle();
        sd[0] = INF_W;
        mr = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("stall_rdy", 64'(rdy_seen), 0);
            check("stall_data", m_data, NAN_W);
        end
        mr = 1;
        cycle();
        check("stall_rel_rdy", 64'(rdy_seen), 1);
        check("stall_inf", m_data, INF_W);
        sv = 0;
        cycle();
        check("drain_valid", 64'(m_valid), 0);

        // reset while a locked word is in the output register
        do_reset();
        sd[2] = 64'h0000_0000_0000_0001;
        sv = 4'b0100;
        cycle();
        cycle();
        rst = 1;
        cycle();
        check("midrst_rdy", 64'(rdy_seen), 0);
        check("midrst_valid", 64'(m_valid), 0);
        rst = 0;
        sv = 4'b0101;
        cycle();
        check("postrst_rdy0", 64'(rdy_seen), 1);

        // random traffic honoring hold-until-ready
        do_reset();
        for (int n = 0; n < 400; n++) begin
            mr = ($urandom % 4) != 0;
            for (int i = 0; i < 4; i++) begin
                if (!sv[i] || rdy_seen[i]) begin
                    sv[i] = ($urandom % 3) != 0;
                    case ($urandom % 5)
                        0: sd[i] = NAN_W;
                        1: sd[i] = 64'h8000_0000_0000_0000;
                        2: sd[i] = 64'h0000_0000_0000_0001;
                        default: sd[i] = {$urandom, $urandom};
                    endcase
                end
            end
            cycle();
        end

`ifdef RVARB_STATS_EN
        do_reset();
        sv = 4'b1000;
        mr = 1;
        repeat (70000) @(negedge clk);
        check("stat3_sat", stat_cnt[63:48], 64'hFFFF);
        check("stat_others", 64'(stat_cnt[47:0]), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
